// File: rtl/param_mem_pkg.sv
// Shared types and helpers for param_mem_ctrl and its read pipeline.
// The parity helper is only referenced when PARAM_MEM_PARITY_EN is defined.
package param_mem_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int RD_LAT_MAX = 4;
   localparam int PAR_MAX_W  = 64;

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: RD_LAT stages of valid/payload registers.
// Payload stages only load when a valid word arrives, so the last stage holds.
module mem_rd_pipe
   import param_mem_pkg::*;
#(
   parameter int W      = 21,
   parameter int RD_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

   logic [LAT-1:0] vld_q;
   logic [W-1:0]   dat_q [LAT];

   // Shift valid every cycle; move payload only alongside a valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= valid_i;
         if (valid_i) begin
            dat_q[0] <= data_i;
         end
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign valid_o = vld_q[LAT-1];
   assign data_o  = dat_q[LAT-1];

endmodule

// File: rtl/param_mem_ctrl.sv
// Parametrised single-port data memory with zero-init sweep, OOB detection and
// configurable read latency. Optional per-word parity: define PARAM_MEM_PARITY_EN.
module param_mem_ctrl
   import param_mem_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int ADDR_W = 15,
   parameter int DEPTH  = 32768,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              init_done,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_di,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_do,
   output logic              rsp_err,
`ifdef PARAM_MEM_PARITY_EN
   output logic              rsp_perr,
`endif
   output logic              wr_oob
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PARAM_MEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
   localparam int RSP_W = DATA_W + 2;
`else
   localparam int MEM_W = DATA_W;
   localparam int RSP_W = DATA_W + 1;
`endif
   localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              wr_oob_q, wr_oob_d;
   logic              init_done_q, req_ready_q;

   logic              acc_s, oob_s;
   logic [IDX_W-1:0]  idx_s;
   logic              mem_we_s;
   logic [IDX_W-1:0]  mem_wa_s;
   logic [MEM_W-1:0]  mem_wd_s;
   logic [MEM_W-1:0]  rd_word_s;
   logic [RSP_W-1:0]  rd_pay_s, rsp_pay_s;

   logic [MEM_W-1:0]  mem_q [DEPTH];

   // Zero-extended compare so DEPTH == 2**ADDR_W never flags out of range.
   assign acc_s = req_valid & req_ready_q;
   assign oob_s = ({1'b0, req_addr} >= DEPTH_X);
   assign idx_s = req_addr[IDX_W-1:0];

   // Sweep sequencing, clear handling and sticky out-of-range write flag.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_oob_d = wr_oob_q;
      case (state_q)
         ST_INIT: begin
            if (clr) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         ST_RUN: begin
            if (clr) begin
               state_d  = ST_INIT;
               cnt_d    = '0;
               wr_oob_d = 1'b0;
            end else if (acc_s && req_we && oob_s) begin
               wr_oob_d = 1'b1;
            end else begin
               wr_oob_d = wr_oob_q;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Control registers; ready/done are registered copies of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         wr_oob_q    <= 1'b0;
         init_done_q <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_oob_q    <= wr_oob_d;
         init_done_q <= (state_d == ST_RUN);
         req_ready_q <= (state_d == ST_RUN);
      end
   end

   // Single write port shared by the sweep and accepted in-range writes.
   always_comb begin
      mem_we_s = 1'b0;
      mem_wa_s = cnt_q;
      mem_wd_s = '0;
      if (state_q == ST_INIT) begin
         mem_we_s = 1'b1;
      end else if (acc_s && req_we && !oob_s) begin
         mem_we_s = 1'b1;
         mem_wa_s = idx_s;
`ifdef PARAM_MEM_PARITY_EN
         mem_wd_s = {even_parity(PAR_MAX_W'(req_di)), req_di};
`else
         mem_wd_s = req_di;
`endif
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Storage array; contents are established by the sweep, not by reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_wa_s] <= mem_wd_s;
      end
   end

   // Read payload: {perr?, err, data}, forced to zero data for OOB addresses.
   always_comb begin
      rd_word_s = mem_q[idx_s];
      rd_pay_s  = '0;
      if (oob_s) begin
         rd_pay_s[DATA_W] = 1'b1;
      end else begin
         rd_pay_s[DATA_W-1:0] = rd_word_s[DATA_W-1:0];
`ifdef PARAM_MEM_PARITY_EN
         rd_pay_s[DATA_W+1] = even_parity(PAR_MAX_W'(rd_word_s[DATA_W-1:0])) ^ rd_word_s[DATA_W];
`endif
      end
   end

   mem_rd_pipe #(
      .W      (RSP_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (acc_s & ~req_we),
      .data_i  (rd_pay_s),
      .valid_o (rsp_valid),
      .data_o  (rsp_pay_s)
   );

   assign rsp_do    = rsp_pay_s[DATA_W-1:0];
   assign rsp_err   = rsp_pay_s[DATA_W];
`ifdef PARAM_MEM_PARITY_EN
   assign rsp_perr  = rsp_pay_s[DATA_W+1];
`endif
   assign init_done = init_done_q;
   assign req_ready = req_ready_q;
   assign wr_oob    = wr_oob_q;

endmodule

// File: doc/param_mem_ctrl.md
Name: param_mem_ctrl

Overview:
- Parametrised single-port synchronous data memory for the CPU datapath. Generalises the fixed 20-bit x 32K word store with:
  - a valid/ready request interface;
  - configurable read latency;
  - non-power-of-two depth with out-of-range detection;
  - a hardware zero-initialisation sweep after reset or on request.
- Sits between the core's load/store unit and the storage array.

Parameters:
- DATA_W, 20, data word width in bits.
- ADDR_W, 15, address width.
- DEPTH, 32768, number of words implemented. Legal range 1 to 2**ADDR_W.
- RD_LAT, 1, read latency in cycles. Legal values 1 to 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  one-cycle pulse; restarts the zero-init sweep.
- init_done  output  1  high when the memory is initialised and accepting requests.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_di  input  DATA_W  write data.
- rsp_valid  output  1  read data valid; one-cycle pulse.
- rsp_do  output  DATA_W  read data.
- rsp_err  output  1  read address was out of range; qualified by rsp_valid.
- wr_oob  output  1  sticky flag: an out-of-range write was dropped.

Behaviour:
- Single clock, clk. Asynchronous active-low reset rst_n.
- Reset values:
  - init_done=0, req_ready=0, rsp_valid=0, rsp_do=0, rsp_err=0, wr_oob=0.
  - FSM in INIT, sweep counter 0, all read-pipeline valid bits cleared.
- FSM states are INIT and RUN.
- INIT state:
  - Each cycle, writes 0 to mem[cnt] and increments cnt.
  - When cnt==DEPTH-1 is written, the next state is RUN.
  - The sweep takes exactly DEPTH cycles.
  - req_ready=0 throughout.
- RUN state:
  - req_ready=1 and init_done=1.
  - clr pulse → next cycle INIT, cnt=0, init_done=0, wr_oob cleared.
- clr during INIT restarts the sweep at cnt=0.
- Acceptance: a request is accepted on a rising edge where req_valid & req_ready. At most one request per cycle.
- Write accepted:
  - If req_addr < DEPTH, mem[req_addr] <= req_di.
  - Otherwise the write is dropped and wr_oob <= 1.
  - Writes produce no response.
- Read accepted at edge N:
  - rsp_valid is high for exactly one cycle, following edge N+RD_LAT-1 (RD_LAT=1 means valid in the cycle after acceptance).
  - rsp_do = mem[req_addr] as of edge N: read-before-write ordering with respect to requests accepted earlier.
  - A write accepted at edge N-1 is visible to a read accepted at edge N.
  - If req_addr >= DEPTH: rsp_do=0 and rsp_err=1.
- Back-to-back reads at full rate produce back-to-back rsp_valid pulses in order.
- There is no response backpressure; the consumer must always sink.
- rsp_do and rsp_err hold their last values while rsp_valid=0.
- Reads in flight when clr arrives still complete; they return the pre-clear contents.
- Asynchronous reset mid-operation discards all in-flight reads (no rsp_valid) and restarts the sweep.
- Address comparison is unsigned at ADDR_W bits. When DEPTH==2**ADDR_W, no address is out of range.

Optional Feature:
- Macro PARAM_MEM_PARITY_EN.
- When defined:
  - Each stored word carries one extra even-parity bit, computed on write. The init sweep writes 0 data with parity 0.
  - On read, parity is recomputed. A new output rsp_perr (1 bit, qualified by rsp_valid, reset 0) is high on mismatch.
- When undefined: no parity storage and no rsp_perr port.

Decomposition:
- Shared package param_mem_pkg holds:
  - FSM state enum (ST_INIT, ST_RUN);
  - RD_LAT_MAX=4;
  - a parity helper function.
- One sub-module, mem_rd_pipe: a RD_LAT-deep valid/data/err shift register that delays the array output. The array and FSM stay in the top module.

Test Plan:
- Reset release, DEPTH=8: req_ready=0 for 8 cycles, then init_done=1. A read of addr 5 returns 0 with rsp_err=0.
- RD_LAT=3: write 0x0ABCD to addr 3, then read addr 3 on the next cycle → rsp_valid exactly 3 cycles after acceptance, rsp_do=0x0ABCD.
- DEPTH=20, ADDR_W=5:
  - read addr 25 → rsp_err=1, rsp_do=0;
  - write addr 31 → wr_oob=1 with no memory change (addr 31 is out of range; readback is not possible);
  - write 0x11 to addr 19, read addr 19 → 0x11.
- Four back-to-back reads of addresses 0..3 holding 0x10..0x13 → four consecutive rsp_valid pulses in that order.
- Write 0xFFFFF to addr 2:
  - read addr 2 in the same cycle as clr → returns 0xFFFFF;
  - after re-init, read addr 2 → returns 0.
- Assert rst_n low while two reads are in flight → no rsp_valid after release until new reads are issued. With PARAM_MEM_PARITY_EN, force-flip a stored bit → rsp_perr=1.
